// File: rtl/ppm_frame_encoder_if.sv
// Control and serial-output bundle for ppm_frame_encoder.
// The master side drives run/polarity/shadow writes; the slave side is the encoder.
interface ppm_frame_encoder_if #(
    parameter int NCH = 4,
    parameter int PW  = 8
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = $clog2(NCH + 1);

    logic          en;
    logic          inv;
    logic          wr;
    logic [CW-1:0] wr_ch;
    logic [PW-1:0] wr_pos;
    logic          ppm_out;
    logic          frame_start;
    logic [SW-1:0] slot_idx;
    logic          busy;

    modport master (
        output en, inv, wr, wr_ch, wr_pos,
        input  ppm_out, frame_start, slot_idx, busy
    );

    modport slave (
        input  en, inv, wr, wr_ch, wr_pos,
        output ppm_out, frame_start, slot_idx, busy
    );
endinterface

// File: rtl/ppm_frame_encoder.sv
// Multi-channel PPM frame generator: NCH data slots plus one sync slot per frame,
// with shadow positions taken up atomically at every frame boundary.
module ppm_frame_encoder #(
    parameter int NCH       = 4,
    parameter int PW        = 8,
    parameter int PULSE_LEN = 4,
    parameter int SYNC_LEN  = 8
) (
    input logic               clk,
    input logic               rst,
    ppm_frame_encoder_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = $clog2(NCH + 1);
    localparam logic [SW-1:0] SYNC_SLOT = SW'(NCH);
    localparam logic [PW:0]   PULSE_W   = (PW+1)'(PULSE_LEN);
    localparam logic [PW:0]   SYNC_W    = (PW+1)'(SYNC_LEN);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] cyc_q, cyc_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [PW-1:0] act_q [NCH];
    logic [PW-1:0] act_d [NCH];
    logic [PW-1:0] shd_q [NCH];
    logic [PW-1:0] shd_d [NCH];
    logic          ppm_q, ppm_d;
    logic          frame_start_q, frame_start_d;
    logic [SW-1:0] slot_idx_q, slot_idx_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] cur_pos;
    logic          raw;

    always_comb begin
        shd_d = shd_q;
        for (int k = 0; k < NCH; k++) begin
            if (bus.wr && (bus.wr_ch == CW'(k))) begin
                shd_d[k] = bus.wr_pos;
            end
        end
    end

    // Loads read shd_q, so a write landing on the load cycle waits one more frame.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        slot_d  = slot_q;
        act_d   = act_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = RUN;
                    act_d   = shd_q;
                    cyc_d   = '0;
                    slot_d  = '0;
                end
            end
            RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == '1) begin
                    if (slot_q == SYNC_SLOT) begin
                        slot_d = '0;
                        if (bus.en) begin
                            act_d = shd_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One bit of headroom lets a late pulse be cut at the slot end rather than wrap.
    always_comb begin
        cur_pos = '0;
        for (int k = 0; k < NCH; k++) begin
            if (slot_q == SW'(k)) begin
                cur_pos = act_q[k];
            end
        end
        raw = 1'b0;
        if (state_q == RUN) begin
            if (slot_q == SYNC_SLOT) begin
                raw = ({1'b0, cyc_q} < SYNC_W);
            end else begin
                raw = ({1'b0, cyc_q} >= {1'b0, cur_pos}) &&
                      ({1'b0, cyc_q} < ({1'b0, cur_pos} + PULSE_W));
            end
        end
        ppm_d         = raw ^ bus.inv;
        frame_start_d = (state_q == RUN) && (slot_q == '0) && (cyc_q == '0);
        slot_idx_d    = slot_q;
        busy_d        = (state_q == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cyc_q         <= '0;
            slot_q        <= '0;
            for (int k = 0; k < NCH; k++) begin
                act_q[k] <= '0;
                shd_q[k] <= '0;
            end
            ppm_q         <= bus.inv;
            frame_start_q <= 1'b0;
            slot_idx_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            slot_q        <= slot_d;
            act_q         <= act_d;
            shd_q         <= shd_d;
            ppm_q         <= ppm_d;
            frame_start_q <= frame_start_d;
            slot_idx_q    <= slot_idx_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.ppm_out     = ppm_q;
    assign bus.frame_start = frame_start_q;
    assign bus.slot_idx    = slot_idx_q;
    assign bus.busy        = busy_q;
endmodule
